xy_trace_monitor: RTL

Receive-side companion to the arithmetic-case stimulus path: samples the `selector`/`x`/`y` signals of the design under mining every enabled cycle. It maintains sticky candidate-invariant flags for property mining and buffers the raw trace in a small FIFO. A valid/ready port drains the FIFO to a logger. It sits beside `top` and never drives it.

---
 rtl/xy_trace_pkg.sv | 15 +
 rtl/xy_trace_fifo.sv | 71 +++++++
 rtl/xy_trace_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/xy_trace_pkg.sv
// Shared types and widths for the x/y trace monitor and its trace FIFO.
package xy_trace_pkg;

    localparam int W_DEF        = 15;
    localparam int REC_W        = 2 * W_DEF + 1;
    localparam int SAMPLE_CNT_W = 16;
    localparam int DROP_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/xy_trace_fifo.sv
// First-word-fall-through FIFO with registered head; extra pointer bit separates full from empty.
module xy_trace_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             drop_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full_s;
    logic             pop_s;
    logic             accept_s;

    assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s    = valid_q && pop_i;
    assign accept_s = push_i && (!full_s || pop_s);
    assign drop_o   = push_i && !accept_s;

    // Pointer advance and look-ahead of the head entry that becomes visible next cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept_s};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_s};
        valid_d  = (wr_ptr_d != rd_ptr_d);
        if (!valid_d) begin
            data_d = '0;
        end else if (accept_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            data_d = wdata_i;
        end else begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array; only written entries are ever read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/xy_trace_monitor.sv
// Passive monitor: mines sticky x/y invariants, counts samples/drops and buffers raw records.
module xy_trace_monitor
    import xy_trace_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic                    selector,
    input  logic [W-1:0]            x,
    input  logic [W-1:0]            y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*W:0]            out_data,
    output logic                    inv_x_nondec,
    output logic                    inv_y_nondec,
    output logic                    inv_sum_const,
    output logic                    inv_x_ge_y,
    output logic                    inv_valid,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic                    overflow
);

    state_e                  state_q, state_d;
    logic                    cmp_en_s, valid_set_s;
    logic [W-1:0]            prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [W:0]              prev_sum_q, prev_sum_d, sum_s;
    logic                    x_nondec_q, x_nondec_d, y_nondec_q, y_nondec_d;
    logic                    sum_const_q, sum_const_d, x_ge_y_q, x_ge_y_d;
    logic                    inv_valid_q, inv_valid_d;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    drop_s;

    // Sum kept one bit wider than the operands so it never wraps.
    assign sum_s = {1'b0, x} + {1'b0, y};

    xy_trace_fifo #(
        .WIDTH (2 * W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (sample_en),
        .wdata_i ({selector, x, y}),
        .pop_i   (out_ready),
        .drop_o  (drop_s),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (sample_en) state_d = ST_FIRST;
                else           state_d = ST_EMPTY;
            end
            ST_FIRST: begin
                if (sample_en) state_d = ST_RUN;
                else           state_d = ST_FIRST;
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs: history comparisons are only meaningful once a previous sample exists.
    always_comb begin
        cmp_en_s    = 1'b0;
        valid_set_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                cmp_en_s    = 1'b0;
                valid_set_s = 1'b0;
            end
            ST_FIRST: begin
                cmp_en_s    = sample_en;
                valid_set_s = sample_en;
            end
            ST_RUN: begin
                cmp_en_s    = sample_en;
                valid_set_s = 1'b0;
            end
            default: begin
                cmp_en_s    = 1'b0;
                valid_set_s = 1'b0;
            end
        endcase
    end

    // Invariant flags, sample history and counters.
    always_comb begin
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_sum_d   = prev_sum_q;
        x_nondec_d   = x_nondec_q;
        y_nondec_d   = y_nondec_q;
        sum_const_d  = sum_const_q;
        x_ge_y_d     = x_ge_y_q;
        inv_valid_d  = inv_valid_q | valid_set_s;
        sample_cnt_d = sample_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q | drop_s;
        if (sample_en) begin
            prev_x_d   = x;
            prev_y_d   = y;
            prev_sum_d = sum_s;
            if (x < y) x_ge_y_d = 1'b0;
            else       x_ge_y_d = x_ge_y_q;
            if (sample_cnt_q != {SAMPLE_CNT_W{1'b1}}) sample_cnt_d = sample_cnt_q + {{(SAMPLE_CNT_W-1){1'b0}}, 1'b1};
            else                                      sample_cnt_d = sample_cnt_q;
        end else begin
            prev_x_d = prev_x_q;
        end
        if (cmp_en_s) begin
            if (x < prev_x_q)       x_nondec_d  = 1'b0;
            else                    x_nondec_d  = x_nondec_q;
            if (y < prev_y_q)       y_nondec_d  = 1'b0;
            else                    y_nondec_d  = y_nondec_q;
            if (sum_s != prev_sum_q) sum_const_d = 1'b0;
            else                     sum_const_d = sum_const_q;
        end else begin
            x_nondec_d = x_nondec_q;
        end
        if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers for history, flags and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_sum_q   <= '0;
            x_nondec_q   <= 1'b1;
            y_nondec_q   <= 1'b1;
            sum_const_q  <= 1'b1;
            x_ge_y_q     <= 1'b1;
            inv_valid_q  <= 1'b0;
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_sum_q   <= prev_sum_d;
            x_nondec_q   <= x_nondec_d;
            y_nondec_q   <= y_nondec_d;
            sum_const_q  <= sum_const_d;
            x_ge_y_q     <= x_ge_y_d;
            inv_valid_q  <= inv_valid_d;
            sample_cnt_q <= sample_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign inv_x_nondec  = x_nondec_q;
    assign inv_y_nondec  = y_nondec_q;
    assign inv_sum_const = sum_const_q;
    assign inv_x_ge_y    = x_ge_y_q;
    assign inv_valid     = inv_valid_q;
    assign sample_cnt    = sample_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;

endmodule
